// File: rtl/shared_timer_sched.sv
// Round-robin scheduler sharing one up-counter among NUM_REQ requesters.
// Each winner runs the counter for (terminal + 1) cycles and gets a one-cycle Done pulse.
module shared_timer_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned COUNTER_SIZE = 16,
    parameter int unsigned PTR_W        = 2
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic [NUM_REQ-1:0]                Req,
    input  logic [NUM_REQ*COUNTER_SIZE-1:0]   ReqTerm,
    output logic [NUM_REQ-1:0]                Grant,
    output logic [NUM_REQ-1:0]                Done,
    output logic                              Busy,
    output logic [COUNTER_SIZE-1:0]           CountVal,
    output logic [PTR_W-1:0]                  Winner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_n;
    logic [PTR_W-1:0]        ptr_q, ptr_n;
    logic [PTR_W-1:0]        winner_n;
    logic [PTR_W-1:0]        pick;
    logic [PTR_W-1:0]        next_ptr;
    logic                    found;
    logic [COUNTER_SIZE-1:0] term_q, term_n;
    logic [COUNTER_SIZE-1:0] count_n;
    logic [NUM_REQ-1:0]      grant_n, done_n;
    logic                    busy_n;

    // First set request at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && Req[(32'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    assign next_ptr = (Winner == PTR_W'(NUM_REQ - 1)) ? '0 : Winner + PTR_W'(1);

    always_comb begin
        state_n  = state_q;
        ptr_n    = ptr_q;
        winner_n = Winner;
        term_n   = term_q;
        count_n  = CountVal;
        grant_n  = Grant;
        done_n   = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_n  = RUN;
                    grant_n  = NUM_REQ'(1) << pick;
                    winner_n = pick;
                    term_n   = ReqTerm[pick*COUNTER_SIZE +: COUNTER_SIZE];
                    count_n  = '0;
                end
            end
            RUN: begin
                // Withdrawal wins over completion: no Done for an abandoned interval
                if ((Req & Grant) == '0) begin
                    state_n = IDLE;
                    grant_n = '0;
                    count_n = '0;
                    ptr_n   = next_ptr;
                end else if (CountVal == term_q) begin
                    state_n = DONE;
                    done_n  = Grant;
                end else begin
                    count_n = CountVal + COUNTER_SIZE'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                count_n = '0;
                ptr_n   = next_ptr;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                count_n = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            term_q   <= '0;
            Grant    <= '0;
            Done     <= '0;
            Busy     <= 1'b0;
            CountVal <= '0;
            Winner   <= '0;
        end else begin
            state_q  <= state_n;
            ptr_q    <= ptr_n;
            term_q   <= term_n;
            Grant    <= grant_n;
            Done     <= done_n;
            Busy     <= busy_n;
            CountVal <= count_n;
            Winner   <= winner_n;
        end
    end

endmodule

// File: tb/tb_shared_timer_sched.sv
// Bench for shared_timer_sched: directed vector table, corner-case sequences,
// and randomized traffic against an interval-based reference model.
module tb_shared_timer_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 2;

    logic            Clk;
    logic            Rst;
    logic [N-1:0]    Req;
    logic [N*CW-1:0] ReqTerm;
    logic [N-1:0]    Grant;
    logic [N-1:0]    Done;
    logic            Busy;
    logic [CW-1:0]   CountVal;
    logic [PW-1:0]   Winner;

    shared_timer_sched #(.NUM_REQ(N), .COUNTER_SIZE(CW), .PTR_W(PW)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqTerm(ReqTerm),
        .Grant(Grant), .Done(Done), .Busy(Busy), .CountVal(CountVal), .Winner(Winner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: owner index (-1 when free), cycles elapsed since grant, captured term
    int m_owner, m_k, m_term, m_ptr, m_winner;

    typedef struct {
        logic [N-1:0]    req;
        logic [N*CW-1:0] terms;
        logic [N-1:0]    grant;
        logic [N-1:0]    done;
        logic            busy;
        logic [CW-1:0]   count;
        logic [PW-1:0]   winner;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(logic [N-1:0] req, logic [N*CW-1:0] terms, logic [N-1:0] grant,
                                 logic [N-1:0] done, logic busy, logic [CW-1:0] count,
                                 logic [PW-1:0] winner);
        vec_t v;
        v.req = req; v.terms = terms; v.grant = grant; v.done = done;
        v.busy = busy; v.count = count; v.winner = winner;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_k = 0; m_term = 0; m_ptr = 0; m_winner = 0;
    endtask

    task automatic model_edge();
        if (Rst) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            if (Req != '0) begin
                for (int i = 0; i < int'(N); i++) begin
                    int c = (m_ptr + i) % int'(N);
                    if (Req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_winner = m_owner;
                m_term   = int'(ReqTerm[m_owner*CW +: CW]);
                m_k      = 0;
            end
        end else if (m_k <= m_term) begin
            if (!Req[m_owner]) begin
                m_ptr   = (m_owner + 1) % int'(N);
                m_owner = -1;
            end else begin
                m_k++;
            end
        end else begin
            m_ptr   = (m_owner + 1) % int'(N);
            m_owner = -1;
        end
    endtask

    function automatic logic [N-1:0] e_grant();
        return (m_owner < 0) ? '0 : N'(1 << m_owner);
    endfunction

    function automatic logic [N-1:0] e_done();
        return (m_owner >= 0 && m_k == m_term + 1) ? e_grant() : '0;
    endfunction

    function automatic logic [CW-1:0] e_count();
        if (m_owner < 0) return '0;
        return (m_k <= m_term) ? CW'(m_k) : CW'(m_term);
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".grant"},  32'(Grant),    32'(e_grant()));
        check({tag, ".done"},   32'(Done),     32'(e_done()));
        check({tag, ".busy"},   32'(Busy),     32'(m_owner >= 0));
        check({tag, ".count"},  32'(CountVal), 32'(e_count()));
        check({tag, ".winner"}, 32'(Winner),   32'(m_winner));
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int starts[$];
        int dones[$];
        logic [N-1:0] pg;
        logic [N-1:0] order[$];
        int ndone;
        int budget;

        // t0=3 then changed to 9 mid-run; then requester 2 withdraws at CountVal=2
        vecs[0]  = mkv(4'b0001, 64'h0000_0000_0000_0003, 4'b0001, 4'b0000, 1'b1, 16'd0, 2'd0);
        vecs[1]  = mkv(4'b0001, 64'h0000_0000_0000_0003, 4'b0001, 4'b0000, 1'b1, 16'd1, 2'd0);
        vecs[2]  = mkv(4'b0001, 64'h0000_0000_0000_0009, 4'b0001, 4'b0000, 1'b1, 16'd2, 2'd0);
        vecs[3]  = mkv(4'b0001, 64'h0000_0000_0000_0009, 4'b0001, 4'b0000, 1'b1, 16'd3, 2'd0);
        vecs[4]  = mkv(4'b0001, 64'h0000_0000_0000_0009, 4'b0001, 4'b0001, 1'b1, 16'd3, 2'd0);
        vecs[5]  = mkv(4'b0000, 64'h0000_0000_0000_0000, 4'b0000, 4'b0000, 1'b0, 16'd0, 2'd0);
        vecs[6]  = mkv(4'b0100, 64'h0000_0005_0000_0000, 4'b0100, 4'b0000, 1'b1, 16'd0, 2'd2);
        vecs[7]  = mkv(4'b0100, 64'h0000_0005_0000_0000, 4'b0100, 4'b0000, 1'b1, 16'd1, 2'd2);
        vecs[8]  = mkv(4'b0100, 64'h0000_0005_0000_0000, 4'b0100, 4'b0000, 1'b1, 16'd2, 2'd2);
        vecs[9]  = mkv(4'b0000, 64'h0000_0005_0000_0000, 4'b0000, 4'b0000, 1'b0, 16'd0, 2'd2);
        vecs[10] = mkv(4'b1001, 64'h0004_0000_0000_0001, 4'b1000, 4'b0000, 1'b1, 16'd0, 2'd3);
        vecs[11] = mkv(4'b0000, 64'h0004_0000_0000_0001, 4'b0000, 4'b0000, 1'b0, 16'd0, 2'd3);

        Rst = 1'b1;
        Req = '0;
        ReqTerm = '0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        check("reset.grant",  32'(Grant),    32'd0);
        check("reset.done",   32'(Done),     32'd0);
        check("reset.busy",   32'(Busy),     32'd0);
        check("reset.count",  32'(CountVal), 32'd0);
        check("reset.winner", 32'(Winner),   32'd0);
        Rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            Req = vecs[i].req;
            ReqTerm = vecs[i].terms;
            tick();
            check($sformatf("v%0d.grant", i),  32'(Grant),    32'(vecs[i].grant));
            check($sformatf("v%0d.done", i),   32'(Done),     32'(vecs[i].done));
            check($sformatf("v%0d.busy", i),   32'(Busy),     32'(vecs[i].busy));
            check($sformatf("v%0d.count", i),  32'(CountVal), 32'(vecs[i].count));
            check($sformatf("v%0d.winner", i), 32'(Winner),   32'(vecs[i].winner));
        end

        // All requesters held, zero terms: strict rotation with one idle gap
        Req = 4'b1111;
        ReqTerm = '0;
        pg = Grant;
        ndone = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            check_model($sformatf("rr%0d", t));
            if (Grant != '0 && pg == '0) order.push_back(Grant);
            if (Done != '0) ndone++;
            pg = Grant;
        end
        Req = '0;
        check("rr.ngrants", 32'(order.size()), 32'd5);
        check("rr.ndone", 32'(ndone), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check($sformatf("rr.order%0d", i), 32'(order[i]), 32'(4'b0001 << (i % 4)));

        // Sole requester 1, term 2: period 5, Done at g+3
        Req = 4'b0010;
        ReqTerm = 64'h0000_0000_0002_0000;
        pg = Grant;
        for (int t = 1; t <= 20; t++) begin
            tick();
            check_model($sformatf("sole%0d", t));
            if (Grant != '0 && pg == '0) starts.push_back(t);
            if (Done != '0) dones.push_back(t);
            pg = Grant;
        end
        Req = '0;
        tick();
        check_model("sole.end");
        check("sole.nstarts", 32'(starts.size()), 32'd4);
        check("sole.ndones", 32'(dones.size()), 32'd4);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("sole.period%0d", i), 32'(starts[i] - starts[i-1]), 32'd5);
        for (int i = 0; i < starts.size() && i < dones.size(); i++)
            check($sformatf("sole.latency%0d", i), 32'(dones[i] - starts[i]), 32'd3);

        // Asynchronous reset mid-run at CountVal=7 of term 10
        Req = 4'b0100;
        ReqTerm = 64'h0000_000A_0000_0000;
        budget = 0;
        do begin
            tick();
            check_model("arst.run");
            budget++;
        end while (CountVal != 16'd7 && budget < 40);
        check("arst.reached7", 32'(CountVal), 32'd7);
        #2 Rst = 1'b1;
        #1;
        check("arst.grant", 32'(Grant),    32'd0);
        check("arst.done",  32'(Done),     32'd0);
        check("arst.busy",  32'(Busy),     32'd0);
        check("arst.count", 32'(CountVal), 32'd0);
        Req = 4'b1010;
        tick();
        check_model("arst.hold");
        Rst = 1'b0;
        tick();
        check("arst.regrant", 32'(Grant), 32'b0010);
        check_model("arst.after");

        // Randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < int'(N); b++)
                if ($urandom_range(7) == 0) Req[b] = ~Req[b];
            if ($urandom_range(3) == 0)
                ReqTerm[$urandom_range(N-1)*CW +: CW] = CW'($urandom_range(7));
            Rst = ($urandom_range(499) == 0);
            tick();
            check_model("rand");
        end
        Rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/shared_timer_sched.md
Name: shared_timer_sched

Overview:
- Round-robin scheduler that shares one up-counter timing resource between NUM_REQ requesters.
- Each requester asks for an interval of (terminal + 1) clock cycles. The block arbitrates, loads and runs the shared counter, then returns a one-cycle completion pulse to the winner.
- Sits between control FSMs and the single timing counter, so one counter instance serves several timed sequences.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- COUNTER_SIZE, 16, width of the shared counter and of each terminal value
- PTR_W, 2, width of the round-robin pointer and Winner; must be ≥ clog2(NUM_REQ)

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Req  input  NUM_REQ  level request per requester, held until Done or withdrawn
- ReqTerm  input  NUM_REQ*COUNTER_SIZE  terminal counts, requester i at bits [i*COUNTER_SIZE +: COUNTER_SIZE]
- Grant  output  NUM_REQ  one-hot owner of the counter, 0 when idle
- Done  output  NUM_REQ  one-hot, one-cycle completion pulse
- Busy  output  1  counter owned (state RUN or DONE)
- CountVal  output  COUNTER_SIZE  current shared counter value
- Winner  output  PTR_W  index of current/last owner

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE; Grant=0, Done=0, Busy=0, CountVal=0, Winner=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - Deassertion is sampled on the next Clk edge.
- All outputs are registered. No combinational Req->Grant path.
- States: IDLE, RUN, DONE.
- IDLE:
  - If Req==0, stay.
  - Otherwise pick the first set Req bit at or after the pointer, wrapping modulo NUM_REQ.
  - Next edge: Grant=onehot(w), Winner=w, Term_q=ReqTerm slice w (captured once and ignored afterwards), CountVal=0, go to RUN.
  - Grant therefore appears 1 cycle after Req is first sampled high.
- RUN:
  - If Req[w]==0 (withdrawn): next edge go to IDLE with Grant=0, CountVal=0, pointer=w+1. No Done pulse.
  - Else if CountVal==Term_q: next edge go to DONE with Done[w]=1 and CountVal held.
  - Else CountVal increments by 1 (COUNTER_SIZE-bit add; wrap is unreachable because Term_q ≤ max).
- DONE:
  - Lasts exactly 1 cycle with Grant and Done[w] high.
  - Next edge: IDLE, Grant=0, Done=0, CountVal=0, pointer=w+1 (mod NUM_REQ).
- Timing from first Grant cycle g:
  - RUN occupies Term+1 cycles.
  - Done is high in cycle g+Term+1.
  - Grant is high for Term+2 cycles.
  - Term=0 gives Done at g+1.
- Arbitration happens only in IDLE, so back-to-back owners have one idle cycle between them.
- Req changes from other requesters during RUN/DONE have no effect.
- Winner keeps its last value while idle.
- A requester that keeps Req high after its Done is re-granted only after all other pending requesters, because the pointer has moved past it. If it is the sole requester it is re-granted on the first IDLE cycle.
- Busy = (state != IDLE).
- Rst asserted mid-RUN: immediate return to reset values, no Done pulse.
- Invariants: Grant and Done are each one-hot or zero, and Done is never set without the matching Grant bit.

Test Plan:
- Reset, then Req=4'b0001 with term0=3 -> Grant=0001 one cycle later, CountVal 0,1,2,3, Done=0001 in cycle g+4, Grant high for 5 cycles, then IDLE.
- Req=4'b1111 held continuously, all terms=0 -> grant order 0,1,2,3,0. Each grant lasts 2 cycles with 1 idle cycle between grants, and exactly one Done pulse per grant.
- Req[2] alone with term=5, Req[2] dropped when CountVal=2 -> Grant=0 next cycle, no Done, next arbitration starts from index 3.
- Rst pulsed asynchronously (mid-cycle) while CountVal=7 of term 10 -> Grant, Busy, CountVal go to 0 at once, no Done; first grant after release goes to the lowest set Req index.
- Sole Req[1] held with term=2 -> Done at g+3, one idle cycle, re-granted. Pattern repeats with a period of 5 cycles.
- ReqTerm[0] changed from 3 to 9 during RUN -> Done still arrives at g+4 (captured term used).
